// File: rtl/ckong_input.sv
// ckong_input: PS/2 key decode, dual-pad merge, orientation remap and coin stretch for Crazy Kong.
// Coin pulse stretching is built only when CKONG_COIN_STRETCH_EN is defined; otherwise coin is coin_req registered.
//
//   state  | meaning
//   C_IDLE | coin low, waiting for a coin_req rising edge
//   C_HOLD | coin high until COIN_FRAMES vblank rises have passed and coin_req is low
module ckong_input #(
    parameter int unsigned COIN_FRAMES = 3
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic [64:0] ps2_key,
    input  logic [15:0] joystick_0,
    input  logic [15:0] joystick_1,
    input  logic        orient,
    input  logic        vblank,
    output logic [6:0]  joy_pcfrldu
);

    localparam int K_UP    = 0;
    localparam int K_DOWN  = 1;
    localparam int K_LEFT  = 2;
    localparam int K_RIGHT = 3;
    localparam int K_FIRE  = 4;
    localparam int K_START = 5;
    localparam int K_COIN  = 6;

    logic        tog_q;
    logic [6:0]  keys_q;
    logic [6:0]  keys_d;
    logic        key_evt;
    logic        key_pressed;
    logic        key_ext;
    logic [8:0]  key_code;

    logic [6:0]  joy;
    logic        up;
    logic        down;
    logic        left;
    logic        right;
    logic        fire;
    logic        start1;
    logic        coin_req;

    logic [5:0]  btn_q;
    logic        coin_q;

    always_comb begin
        key_evt     = (ps2_key[64] != tog_q);
        key_pressed = (ps2_key[15:8] != 8'hF0);
        key_ext     = key_pressed ? (ps2_key[15:8] == 8'hE0) : (ps2_key[23:16] == 8'hE0);
        // PrtScr/Pause carry extra bytes; collapse them to a code nothing matches
        key_code    = (ps2_key[63:24] != 40'd0) ? 9'd0 : {key_ext, ps2_key[7:0]};
    end

    always_comb begin
        keys_d = keys_q;
        if (key_evt) begin
            case (key_code)
                9'h075, 9'h175: keys_d[K_UP]    = key_pressed;
                9'h072, 9'h172: keys_d[K_DOWN]  = key_pressed;
                9'h06B, 9'h16B: keys_d[K_LEFT]  = key_pressed;
                9'h074, 9'h174: keys_d[K_RIGHT] = key_pressed;
                9'h029:         keys_d[K_FIRE]  = key_pressed;
                9'h005:         keys_d[K_START] = key_pressed;
                9'h004:         keys_d[K_COIN]  = key_pressed;
                default: ;
            endcase
        end
    end

    always_comb begin
        joy = joystick_0[6:0] | joystick_1[6:0];
        if (orient) begin
            up    = keys_q[K_LEFT]  | joy[1];
            down  = keys_q[K_RIGHT] | joy[0];
            left  = keys_q[K_DOWN]  | joy[2];
            right = keys_q[K_UP]    | joy[3];
        end else begin
            up    = keys_q[K_UP]    | joy[3];
            down  = keys_q[K_DOWN]  | joy[2];
            left  = keys_q[K_LEFT]  | joy[1];
            right = keys_q[K_RIGHT] | joy[0];
        end
        fire     = keys_q[K_FIRE]  | joy[4];
        start1   = keys_q[K_START] | joy[5];
        coin_req = keys_q[K_COIN]  | joy[6];
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            tog_q  <= ps2_key[64];
            keys_q <= '0;
            btn_q  <= '0;
        end else begin
            tog_q  <= ps2_key[64];
            keys_q <= keys_d;
            btn_q  <= {start1, fire, right, left, down, up};
        end
    end

`ifdef CKONG_COIN_STRETCH_EN
    localparam logic [3:0] CF = 4'(COIN_FRAMES);

    typedef enum logic {
        C_IDLE,
        C_HOLD
    } coin_state_e;

    coin_state_e state_q;
    logic [3:0]  cnt_q;
    logic [3:0]  cnt_nx;
    logic        vblank_q;
    logic        vb_rise;
    logic        coin_req_q;
    logic        coin_rise;

    always_comb begin
        vb_rise   = vblank & ~vblank_q;
        coin_rise = coin_req & ~coin_req_q;
        cnt_nx    = (vb_rise && (cnt_q != CF)) ? cnt_q + 4'd1 : cnt_q;
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q    <= C_IDLE;
            cnt_q      <= 4'd0;
            coin_q     <= 1'b0;
            vblank_q   <= vblank;
            coin_req_q <= coin_req;
        end else begin
            vblank_q   <= vblank;
            coin_req_q <= coin_req;
            case (state_q)
                C_IDLE: begin
                    // a vblank rise in the trigger cycle is deliberately not counted
                    if (coin_rise) begin
                        state_q <= C_HOLD;
                        cnt_q   <= 4'd0;
                        coin_q  <= 1'b1;
                    end else begin
                        coin_q  <= 1'b0;
                    end
                end
                C_HOLD: begin
                    cnt_q <= cnt_nx;
                    if ((cnt_nx == CF) && !coin_req) begin
                        state_q <= C_IDLE;
                        coin_q  <= 1'b0;
                    end else begin
                        coin_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= C_IDLE;
                    coin_q  <= 1'b0;
                end
            endcase
        end
    end

    logic unused_inputs;
    assign unused_inputs = ^{joystick_0[15:7], joystick_1[15:7]};
`else
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            coin_q <= 1'b0;
        end else begin
            coin_q <= coin_req;
        end
    end

    logic unused_inputs;
    assign unused_inputs = ^{joystick_0[15:7], joystick_1[15:7], vblank, (COIN_FRAMES != 0)};
`endif

    assign joy_pcfrldu = {coin_q, btn_q};

endmodule

// File: tb/tb_ckong_input.sv
// Randomized + directed bench for ckong_input: a reference model pushes per-clock expectations into a queue,
// a negedge monitor pops and compares. Works with or without CKONG_COIN_STRETCH_EN.
module tb_ckong_input;

    localparam int CF = 3;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic [64:0] ps2_key;
    logic [15:0] joystick_0;
    logic [15:0] joystick_1;
    logic        orient;
    logic        vblank;
    logic [6:0]  joy_pcfrldu;

    always #5 clk_sys = ~clk_sys;

    ckong_input #(.COIN_FRAMES(CF)) dut (
        .clk_sys     (clk_sys),
        .reset       (reset),
        .ps2_key     (ps2_key),
        .joystick_0  (joystick_0),
        .joystick_1  (joystick_1),
        .orient      (orient),
        .vblank      (vblank),
        .joy_pcfrldu (joy_pcfrldu)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int n_cyc    = 0;

    logic [6:0] exp_q[$];
    logic [6:0] mon_e;

    // reference model state: which functions are held on the keyboard
    logic m_tog;
    logic k_up, k_down, k_left, k_right, k_fire, k_start, k_coin;
    logic m_creq_prev;
`ifdef CKONG_COIN_STRETCH_EN
    logic m_vb_prev;
    logic m_hold;
    int   m_frames;
`endif

    logic [7:0] codes [10] = '{8'h75, 8'h72, 8'h6B, 8'h74, 8'h29, 8'h05, 8'h04, 8'h1C, 8'h5A, 8'h76};

    always @(negedge clk_sys) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            n_checks++;
            if (joy_pcfrldu !== mon_e) begin
                n_fail++;
                $display("FAIL scoreboard cycle=%0d got=%b exp=%b", n_cyc, joy_pcfrldu, mon_e);
            end
        end
    end

    task automatic decode_event();
        logic rel;
        logic ext;
        rel = (ps2_key[15:8] == 8'hF0);
        ext = rel ? (ps2_key[23:16] == 8'hE0) : (ps2_key[15:8] == 8'hE0);
        if (ps2_key[63:24] != 40'd0) return;
        case (ps2_key[7:0])
            8'h75: k_up    = !rel;
            8'h72: k_down  = !rel;
            8'h6B: k_left  = !rel;
            8'h74: k_right = !rel;
            8'h29: if (!ext) k_fire  = !rel;
            8'h05: if (!ext) k_start = !rel;
            8'h04: if (!ext) k_coin  = !rel;
            default: ;
        endcase
    endtask

    task automatic model_step(output logic [6:0] e);
        logic [6:0] joy;
        logic creq, up, dn, lf, rt, coin;
        joy  = joystick_0[6:0] | joystick_1[6:0];
        creq = k_coin | joy[6];
        if (reset) begin
            e = '0;
            m_tog = ps2_key[64];
            {k_up, k_down, k_left, k_right, k_fire, k_start, k_coin} = '0;
            m_creq_prev = creq;
`ifdef CKONG_COIN_STRETCH_EN
            m_vb_prev = vblank;
            m_hold    = 1'b0;
            m_frames  = 0;
`endif
            return;
        end
        if (!orient) begin
            up = k_up | joy[3];    dn = k_down | joy[2];
            lf = k_left | joy[1];  rt = k_right | joy[0];
        end else begin
            up = k_left | joy[1];  dn = k_right | joy[0];
            lf = k_down | joy[2];  rt = k_up | joy[3];
        end
`ifdef CKONG_COIN_STRETCH_EN
        if (!m_hold) begin
            if (creq && !m_creq_prev) begin
                m_hold   = 1'b1;
                m_frames = 0;
            end
        end else begin
            if (vblank && !m_vb_prev && m_frames < CF) m_frames++;
            if (m_frames >= CF && !creq) m_hold = 1'b0;
        end
        coin = m_hold;
        m_vb_prev = vblank;
`else
        coin = creq;
`endif
        e = {coin, k_start | joy[5], k_fire | joy[4], rt, lf, dn, up};
        if (ps2_key[64] != m_tog) decode_event();
        m_tog = ps2_key[64];
        m_creq_prev = creq;
    endtask

    task automatic cyc();
        logic [6:0] e;
        model_step(e);
        @(posedge clk_sys);
        exp_q.push_back(e);
        n_cyc++;
        #1;
    endtask

    task automatic check(input string name, input logic [6:0] exp);
        n_checks++;
        if (joy_pcfrldu !== exp) begin
            n_fail++;
            $display("FAIL %s got=%b exp=%b", name, joy_pcfrldu, exp);
        end
    endtask

    task automatic key(input logic [7:0] sc, input bit ext, input bit rel, input bit prt);
        logic [64:0] k;
        k = '0;
        k[64] = ~ps2_key[64];
        k[7:0] = sc;
        if (rel) begin
            k[15:8] = 8'hF0;
            if (ext) k[23:16] = 8'hE0;
        end else if (ext) begin
            k[15:8] = 8'hE0;
        end
        if (prt) k[63:24] = 40'hE012E0_F07C;
        ps2_key = k;
        cyc();
    endtask

    task automatic frame_check(input string name, input logic [6:0] exp);
        vblank = 1'b1;
        cyc();
        check(name, exp);
        cyc();
        vblank = 1'b0;
        repeat (4) cyc();
    endtask

    initial begin
        int r, idx;
        reset      = 1'b1;
        ps2_key    = '0;
        ps2_key[64] = 1'b1;
        joystick_0 = '0;
        joystick_1 = '0;
        orient     = 1'b0;
        vblank     = 1'b0;
        repeat (3) cyc();
        check("reset_out", 7'b0);
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cyc();
            check("post_reset_quiet", 7'b0);
        end

        key(8'h75, 0, 0, 0);
        check("up_press_1clk", 7'b0000000);
        cyc();
        check("up_press_2clk", 7'b0000001);
        key(8'h75, 0, 1, 0);
        check("up_release_1clk", 7'b0000001);
        cyc();
        check("up_release_2clk", 7'b0000000);

        orient = 1'b1;
        joystick_1[3] = 1'b1;
        cyc();
        check("horz_pad_up_is_right", 7'b0001000);
        joystick_1[3] = 1'b0;
        key(8'h75, 0, 0, 0);
        cyc();
        check("horz_key_up_is_right", 7'b0001000);
        orient = 1'b0;
        cyc();
        check("vert_key_up_restored", 7'b0000001);
        key(8'h75, 0, 1, 0);
        cyc();
        check("up_clear", 7'b0);

        key(8'h6B, 1, 0, 0);
        cyc();
        check("ext_left_press", 7'b0000100);
        key(8'h6B, 1, 1, 0);
        cyc();
        check("ext_left_release", 7'b0);
        key(8'h29, 0, 0, 1);
        cyc();
        cyc();
        check("prtscr_ignored", 7'b0);
        key(8'h29, 0, 0, 0);
        joystick_0[4] = 1'b1;
        cyc();
        check("fire_key_or_pad", 7'b0010000);
        joystick_0[4] = 1'b0;
        key(8'h29, 0, 1, 0);
        cyc();
        check("fire_clear", 7'b0);

        joystick_0[6] = 1'b1;
        cyc();
        check("coin_pulse_seen", 7'b1000000);
        joystick_0[6] = 1'b0;
        cyc();
`ifdef CKONG_COIN_STRETCH_EN
        check("coin_stretched", 7'b1000000);
        cyc();
        frame_check("coin_f1", 7'b1000000);
        frame_check("coin_f2", 7'b1000000);
        frame_check("coin_f3_drop", 7'b0);

        joystick_0[6] = 1'b1;
        cyc();
        joystick_0[6] = 1'b0;
        cyc();
        frame_check("retrig_f1", 7'b1000000);
        joystick_0[6] = 1'b1;
        cyc();
        joystick_0[6] = 1'b0;
        cyc();
        frame_check("retrig_f2", 7'b1000000);
        frame_check("retrig_f3_drop", 7'b0);

        vblank = 1'b1;
        joystick_0[6] = 1'b1;
        cyc();
        check("coin_same_cycle_vb", 7'b1000000);
        joystick_0[6] = 1'b0;
        cyc();
        vblank = 1'b0;
        repeat (4) cyc();
        frame_check("samecyc_f1", 7'b1000000);
        frame_check("samecyc_f2", 7'b1000000);
        frame_check("samecyc_f3_drop", 7'b0);
`else
        check("coin_unstretched", 7'b0);
        cyc();
`endif

        key(8'h04, 0, 0, 0);
        cyc();
        check("f3_press", 7'b1000000);
        for (int f = 0; f < 5; f++) frame_check("f3_held", 7'b1000000);
        key(8'h04, 0, 1, 0);
        check("f3_release_1clk", 7'b1000000);
        cyc();
        check("f3_release_2clk", 7'b0);

        for (int i = 0; i < 4000; i++) begin
            vblank = ((i % 17) < 3);
            r = $urandom_range(0, 99);
            if (r < 12) begin
                idx = $urandom_range(0, 9);
                key(codes[idx], $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1,
                    $urandom_range(0, 19) == 0);
            end else begin
                if (r < 20) begin
                    idx = $urandom_range(0, 6);
                    joystick_0[idx] = ~joystick_0[idx];
                end else if (r < 28) begin
                    idx = $urandom_range(0, 6);
                    joystick_1[idx] = ~joystick_1[idx];
                end else if (r < 31) begin
                    orient = ~orient;
                end else if (r == 31) begin
                    joystick_0[15:7] = 9'($urandom);
                    joystick_1[15:7] = 9'($urandom);
                end else if (r == 32 && $urandom_range(0, 9) == 0) begin
                    reset = 1'b1;
                end
                cyc();
                reset = 1'b0;
            end
        end

        @(negedge clk_sys);
        #1;
        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_drain left=%0d exp=0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ckong_input.md
# ckong_input

Player-input front end for the Crazy Kong core. Sits directly upstream of the `ckong` core's `joy_pcfrldu` port in `emu`:
- decodes PS/2 key events from `hps_io` into held button states;
- merges them with both MiSTer joysticks;
- applies the Vert/Horz orientation remap;
- stretches coin presses to a guaranteed minimum width in frames so the game's vblank-rate input poll cannot miss one.

## Interface
Parameters:
- COIN_FRAMES, 3, minimum coin-high width, counted in vblank rising edges (1..15)

Ports:
- clk_sys  in  1  system clock (same domain as `ckong`)
- reset  in  1  synchronous, active-high
- ps2_key  in  65  `hps_io` key bus:
  - [64] toggles once per event;
  - [7:0] scan code;
  - [15:8]==F0 marks a release;
  - E0 marks extended, in [15:8] for a press and [23:16] for a release;
  - [63:24]!=0 marks PrtScr/Pause.
- joystick_0  in  16  pad 0: [0]R [1]L [2]D [3]U [4]jump [5]start [6]coin
- joystick_1  in  16  pad 1, same layout
- orient  in  1  0 = Vert, 1 = Horz (status[2])
- vblank  in  1  from `ckong`; used only by the coin stretcher
- joy_pcfrldu  out  7  registered {coin, start1, fire, right, left, down, up}, active-high

## Operation
Key event detection:
- tog_q holds the previous ps2_key[64].
- An event occurs on any cycle where ps2_key[64] != tog_q.
- On an event, pressed = ([15:8] != F0).
- Extended flag: if pressed, ext = ([15:8]==E0); otherwise ext = ([23:16]==E0).
- Code is {ext,[7:0]}, forced to 0 when [63:24] != 0.

Key map (the matching held bit is set to `pressed`; unmatched codes are ignored):
- x75 up, x72 down, x6B left, x74 right (extended flag ignored)
- 029 fire (space)
- 005 start1 (F1)
- 004 coin (F3)

Merge and remap:
- joy = joystick_0 | joystick_1.
- Vert (orient=0): U = k_up|joy[3], D = k_down|joy[2], L = k_left|joy[1], R = k_right|joy[0].
- Horz (orient=1): U = k_left|joy[1], D = k_right|joy[0], L = k_down|joy[2], R = k_up|joy[3].
- fire = k_fire|joy[4]; start1 = k_start|joy[5]; coin_req = k_coin|joy[6].
- The coin output comes from the stretcher (see Configuration).

Coin stretcher state machine:
- IDLE:
  - coin=0.
  - On a coin_req rising edge: go to HOLD, cnt=0.
- HOLD:
  - coin=1.
  - cnt increments on each vblank rising edge, saturating at COIN_FRAMES.
  - When cnt==COIN_FRAMES and coin_req=0: go to IDLE.
  - While cnt<COIN_FRAMES, coin_req edges are ignored (no retrigger, no count reset).
  - When cnt==COIN_FRAMES with coin_req still 1: stay in HOLD; coin follows coin_req.
- A vblank rising edge and a coin_req rising edge in the same cycle while in IDLE: enter HOLD with cnt=0. That vblank edge is not counted.

## Timing
- Reset:
  - all held key bits 0, joy_pcfrldu = 0, stretcher IDLE, cnt=0.
  - tog_q loads ps2_key[64], so the first cycle after reset produces no event.
  - coin_req edge detector and vblank edge detector are loaded with current inputs.
- Latency:
  - ps2_key[64] toggle → held bit updates at the next edge → joy_pcfrldu at the edge after that (2 clocks).
  - joystick change → joy_pcfrldu: 1 clock.
  - orient change: 1 clock, and no held state is altered.
- Press and release of the same key are separate events, each taking effect 2 clocks after its toggle.
- Reset asserted mid-HOLD aborts to IDLE and drops coin on the next edge.
- Simultaneous key and pad inputs for the same function: OR.
- Opposing directions are not masked.

## Configuration
- Macro CKONG_COIN_STRETCH_EN.
- Defined: stretcher as described above.
- Undefined: stretcher, cnt and vblank edge detector are compiled out. coin = coin_req registered (1-clock latency, same as the other bits), and COIN_FRAMES is unused.

## Test plan
- Reset with ps2_key[64]=1: no event fires; joy_pcfrldu=0 for 10 clocks after reset deasserts.
- ps2_key={0,...,00,75} with toggle flip, orient=0: joy_pcfrldu=7'b0000001 two clocks later. Then send {..,F0,75} with toggle flip: returns to 0 two clocks after.
- orient=1, joystick_1[3]=1: joy_pcfrldu[0]=0 and [3]=1 (right) one clock later. Clear the joystick and set orient=0 with k_up held: bit0=1.
- COIN_FRAMES=3, stretch enabled, joystick_0[6] pulsed for 1 clock: coin=1 until the 3rd vblank rising edge, then 0. A second pulse between frames 1 and 2 leaves the deassert point unchanged.
- F3 held across 5 vblanks, then released: coin stays 1 until 2 clocks after the release event.
- Extended code E0 6B press then E0 F0 6B release: left sets then clears. The PrtScr sequence ([63:24]!=0) changes nothing.
